// File: rtl/rv32_pipe_pkg.sv
// Shared RV32I pipeline definitions: opcodes, branch funct3 codes, the
// branch-resolve FSM state type and the "instruction writes a register" test.
package rv32_pipe_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } brs_state_t;

   // True when the instruction commits a result to a non-zero rd.
   function automatic logic writes_rd(input logic [31:0] instr);
      logic result;
      logic unused_bits;
      unused_bits = ^instr[31:12];
      result      = 1'b0;
      if (instr[11:7] != 5'd0) begin
         case (instr[6:0])
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: result = 1'b1;
            default:                      result = 1'b0;
         endcase
      end
      return result;
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition and control-transfer target computation
// for the instruction held in ID.
module branch_cmp
   import rv32_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            taken,
   output logic            f3_valid,
   output logic [XLEN-1:0] target
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] imm_i;
   logic            eq;
   logic            lt_s;
   logic            lt_u;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];

   assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};

   assign eq   = (operand_a == operand_b);
   assign lt_s = ($signed(operand_a) < $signed(operand_b));
   assign lt_u = (operand_a < operand_b);

   always_comb begin
      taken    = 1'b0;
      f3_valid = 1'b0;
      target   = '0;
      case (opcode)
         OPC_BRANCH: begin
            target = pc + imm_b;
            case (funct3)
               F3_BEQ:  begin taken = eq;    f3_valid = 1'b1; end
               F3_BNE:  begin taken = !eq;   f3_valid = 1'b1; end
               F3_BLT:  begin taken = lt_s;  f3_valid = 1'b1; end
               F3_BGE:  begin taken = !lt_s; f3_valid = 1'b1; end
               F3_BLTU: begin taken = lt_u;  f3_valid = 1'b1; end
               F3_BGEU: begin taken = !lt_u; f3_valid = 1'b1; end
               default: begin taken = 1'b0;  f3_valid = 1'b0; end
            endcase
         end
         OPC_JAL: begin
            taken  = 1'b1;
            target = pc + imm_j;
         end
         OPC_JALR: begin
            taken  = 1'b1;
            target = (operand_a + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
         end
         default: begin
            taken  = 1'b0;
            target = '0;
         end
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage control-flow resolver: stalls on producer hazards the forwarding
// path cannot cover, resolves branches/jumps, redirects fetch and counts events.
module branch_resolve_unit
   import rv32_pipe_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_id_valid,
   input  logic [31:0]      if_id_instr,
   input  logic [XLEN-1:0]  if_id_pc,
   input  logic [31:0]      id_ex_instr,
   input  logic [31:0]      ex_mem_instr,
   input  logic [XLEN-1:0]  cmp_operand_a,
   input  logic [XLEN-1:0]  cmp_operand_b,
   output logic             stall,
   output logic             flush_if_id,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_target,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   brs_state_t       state_reg, state_next;
   logic             cnt_reg, cnt_next;
   logic [CNT_W-1:0] branch_cnt_reg, taken_cnt_reg, stall_cnt_reg;

   logic [6:0]  opcode;
   logic [4:0]  rs1, rs2;
   logic        is_branch, is_jal, is_jalr, is_ctrl_op, ctrl;
   logic        use_rs1, use_rs2;
   logic [31:0] prod_instr [2];
   logic [1:0]  prod_hit, prod_load;
   logic [1:0]  need;
   logic        stall_int, resolve;
   logic        cmp_taken, cmp_f3_valid;
   logic [XLEN-1:0] cmp_target;

   assign opcode     = if_id_instr[6:0];
   assign rs1        = if_id_instr[19:15];
   assign rs2        = if_id_instr[24:20];
   assign is_branch  = (opcode == OPC_BRANCH);
   assign is_jal     = (opcode == OPC_JAL);
   assign is_jalr    = (opcode == OPC_JALR);
   assign is_ctrl_op = is_branch | is_jal | is_jalr;
   assign ctrl       = if_id_valid & is_ctrl_op;
   assign use_rs1    = is_branch | is_jalr;
   assign use_rs2    = is_branch;

   // Index 0 is the ID/EX producer, index 1 the EX/MEM producer.
   assign prod_instr[0] = id_ex_instr;
   assign prod_instr[1] = ex_mem_instr;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_prod
         logic [4:0] rd;
         assign rd            = prod_instr[gi][11:7];
         assign prod_hit[gi]  = writes_rd(prod_instr[gi]) &&
                                ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
         assign prod_load[gi] = (prod_instr[gi][6:0] == OPC_LOAD);
      end
   endgenerate

   // A non-load in EX/MEM is covered by forwarding; only its load case stalls.
   always_comb begin
      need = 2'd0;
      if (prod_hit[1] && prod_load[1]) need = 2'd1;
      if (prod_hit[0])                 need = prod_load[0] ? 2'd2 : 2'd1;
   end

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .instr     (if_id_instr),
      .pc        (if_id_pc),
      .operand_a (cmp_operand_a),
      .operand_b (cmp_operand_b),
      .taken     (cmp_taken),
      .f3_valid  (cmp_f3_valid),
      .target    (cmp_target)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      stall_int  = 1'b0;
      resolve    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ctrl) begin
               if (need == 2'd0) begin
                  resolve = 1'b1;
               end else begin
                  stall_int  = 1'b1;
                  cnt_next   = (need == 2'd2);
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            // Hazard was settled on entry; IF/ID is held, so resolve on the opcode alone.
            if (cnt_reg) begin
               stall_int = 1'b1;
               cnt_next  = 1'b0;
            end else begin
               resolve    = is_ctrl_op;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign stall           = stall_int & ~rst;
   assign redirect_valid  = resolve & cmp_taken & ~rst;
   assign flush_if_id     = redirect_valid;
   assign redirect_target = redirect_valid ? cmp_target : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt_reg <= '0;
         taken_cnt_reg  <= '0;
         stall_cnt_reg  <= '0;
      end else begin
         if (resolve && is_branch && cmp_f3_valid) branch_cnt_reg <= branch_cnt_reg + CNT_W'(1);
         if (redirect_valid)                       taken_cnt_reg  <= taken_cnt_reg + CNT_W'(1);
         if (stall)                                stall_cnt_reg  <= stall_cnt_reg + CNT_W'(1);
      end
   end

   assign branch_cnt = rst ? '0 : branch_cnt_reg;
   assign taken_cnt  = rst ? '0 : taken_cnt_reg;
   assign stall_cnt  = rst ? '0 : stall_cnt_reg;

endmodule
